// File: rtl/spi_pkg.sv
// Shared SPI definitions for the responder transmitter and the read master.
// Provides the FSM state encoding, SPI mode constants and the default frame length.
package spi_pkg;

  // Mode 0: clock idles low, data sampled on the rising edge.
  localparam bit          SPI_CPOL       = 1'b0;
  localparam bit          SPI_CPHA       = 1'b0;
  localparam int unsigned DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } spi_state_t;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous level into clk and derives one-cycle edge strobes.
// Ports: clk, rst (async active-high), din (async input), level (synced),
//        rise / fall (one clk wide, derived from the synced level and one
//        extra edge-detect flop).
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus edge-detect flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 responder transmitter with a one-deep holding register.
// Ports: clk, rst (async active-high); SCLK, CS (from master, async to clk);
//        SDO (serial out, MSB first, registered); d_in/wr (word queue write);
//        ready (hold empty); busy (frame shifting); done, underrun, abort
//        (one-cycle status pulses).
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int unsigned        DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  IDLE_WORD   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              CS,
  output logic              SDO,
  input  logic [DATA_W-1:0] d_in,
  input  logic              wr,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              abort
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SCLK),
    .level(sclk_level),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (CS),
    .level(cs_level),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_state_t        state;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  bit_cnt;

  logic take_c;
  logic load_c;
  logic last_rise_c;

  // A frame start empties the hold, so a write in that same cycle is accepted
  // even though ready is still low.
  assign take_c      = (state == IDLE) && cs_fall;
  assign load_c      = wr && (!hold_full || take_c);
  assign last_rise_c = sclk_rise && (bit_cnt == CNT_W'(DATA_W - 1));

  // Holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      ready     <= 1'b1;
    end else if (load_c) begin
      hold      <= d_in;
      hold_full <= 1'b1;
      ready     <= 1'b0;
    end else if (take_c) begin
      hold_full <= 1'b0;
      ready     <= 1'b1;
    end
  end

  // Frame FSM, shift register, bit counter and status strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      SDO      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
    end else begin
      done     <= 1'b0;
      underrun <= 1'b0;
      abort    <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            if (hold_full) begin
              shift <= hold;
              SDO   <= hold[DATA_W-1];
            end else begin
              shift    <= IDLE_WORD;
              SDO      <= IDLE_WORD[DATA_W-1];
              underrun <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
          end
        end

        SHIFT: begin
          if (last_rise_c) begin
            // Completion wins over a coincident CS release.
            bit_cnt <= CNT_W'(DATA_W);
            done    <= 1'b1;
            SDO     <= 1'b0;
            busy    <= 1'b0;
            state   <= cs_rise ? IDLE : TAIL;
          end else if (cs_rise) begin
            abort <= 1'b1;
            SDO   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end else if (sclk_fall && (bit_cnt != '0) && (bit_cnt < CNT_W'(DATA_W))) begin
            // A fall before the first rise is the idle-low clock settling; skip it.
            shift <= {shift[DATA_W-2:0], 1'b0};
            SDO   <= shift[DATA_W-2];
          end
        end

        TAIL: begin
          SDO <= 1'b0;
          if (cs_rise) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          SDO   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
